// File: rtl/fetch_npc_stage_if.sv
// IF-stage bundle between the fetch stage, the ID/hazard logic and the
// combinational instruction memory. The fetch stage uses the slave modport;
// the surrounding pipeline (or a testbench) uses the master modport.
interface fetch_npc_stage_if;
  logic        stall;    // hold PC and IF/ID this cycle
  logic        flush_d;  // clear IF/ID to NOP (only when the flush option is built in)
  logic        cmp_eq;   // ID-stage rs==rt after forwarding
  logic [2:0]  npc_op;   // ID-stage next-PC operation
  logic [25:0] imm26_d;  // instr_d[25:0]
  logic [31:0] jr_addr;  // forwarded rs for jr
  logic [31:0] instr_f;  // IM word at pc_f
  logic [31:0] pc_f;     // fetch address to IM
  logic [31:0] instr_d;  // IF/ID instruction
  logic [31:0] pc_d;     // IF/ID PC
  logic [31:0] pc8_d;    // IF/ID PC+8 link value

  modport master (
    output stall, flush_d, cmp_eq, npc_op, imm26_d, jr_addr, instr_f,
    input  pc_f, instr_d, pc_d, pc8_d
  );

  modport slave (
    input  stall, flush_d, cmp_eq, npc_op, imm26_d, jr_addr, instr_f,
    output pc_f, instr_d, pc_d, pc8_d
  );
endinterface

// File: rtl/fetch_npc_stage.sv
// IF stage of a 5-stage MIPS pipeline: PC register, next-PC selection for
// branches/jumps resolved in ID (one delay slot), and the IF/ID register.
// Optional feature macro: IFID_FLUSH_EN -- when defined, flush_d clears IF/ID
// to NOP; when undefined, flush_d is ignored.
module fetch_npc_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic               clk,
  input logic               reset,
  fetch_npc_stage_if.slave  bus
);

  localparam logic [2:0] NPC_SEQ = 3'd0;
  localparam logic [2:0] NPC_BEQ = 3'd1;
  localparam logic [2:0] NPC_BNE = 3'd2;
  localparam logic [2:0] NPC_JMP = 3'd3;
  localparam logic [2:0] NPC_JR  = 3'd4;

`ifdef IFID_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic [31:0] pc_f_q,    pc_f_d;
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pc_d_q,    pc_d_d;
  logic [31:0] pc8_d_q,   pc8_d_d;

  logic [31:0] seq_pc;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_target;
  logic [31:0] next_pc;
  logic        flush_take;

  // Branch target is relative to the instruction in ID, not the fetch PC;
  // jr silently drops the two low address bits instead of trapping.
  always_comb begin
    seq_pc    = bus.pc_f + 32'd4;
    br_target = pc_d_q + 32'd4 + {{14{bus.imm26_d[15]}}, bus.imm26_d[15:0], 2'b00};
    j_target  = {pc_d_q[31:28], bus.imm26_d, 2'b00};
    jr_target = bus.jr_addr & 32'hFFFF_FFFC;
  end

  // Next-PC select; unused opcodes fall through to sequential fetch.
  always_comb begin
    next_pc = seq_pc;
    case (bus.npc_op)
      NPC_SEQ: next_pc = seq_pc;
      NPC_BEQ: next_pc = bus.cmp_eq  ? br_target : seq_pc;
      NPC_BNE: next_pc = !bus.cmp_eq ? br_target : seq_pc;
      NPC_JMP: next_pc = j_target;
      NPC_JR:  next_pc = jr_target;
      default: next_pc = seq_pc;
    endcase
  end

  // Next-state for PC and IF/ID: stall holds everything, flush only empties
  // IF/ID while fetch keeps advancing (the delay slot itself is never flushed
  // by this logic; squashing is the caller's decision).
  always_comb begin
    flush_take = FLUSH_EN && bus.flush_d;
    pc_f_d     = pc_f_q;
    instr_d_d  = instr_d_q;
    pc_d_d     = pc_d_q;
    pc8_d_d    = pc8_d_q;
    if (!bus.stall) begin
      pc_f_d = next_pc;
      if (flush_take) begin
        instr_d_d = NOP_WORD;
        pc_d_d    = 32'd0;
        pc8_d_d   = 32'd0;
      end else begin
        instr_d_d = bus.instr_f;
        pc_d_d    = pc_f_q;
        pc8_d_d   = pc_f_q + 32'd8;
      end
    end
  end

  // State registers with asynchronous reset to the boot PC and an empty IF/ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f_q    <= PC_RESET;
      instr_d_q <= NOP_WORD;
      pc_d_q    <= 32'd0;
      pc8_d_q   <= 32'd0;
    end else begin
      pc_f_q    <= pc_f_d;
      instr_d_q <= instr_d_d;
      pc_d_q    <= pc_d_d;
      pc8_d_q   <= pc8_d_d;
    end
  end

  assign bus.pc_f    = pc_f_q;
  assign bus.instr_d = instr_d_q;
  assign bus.pc_d    = pc_d_q;
  assign bus.pc8_d   = pc8_d_q;

endmodule

// File: tb/tb_fetch_npc_stage.sv
// Directed testbench for fetch_npc_stage. Expectations follow the build's
// IFID_FLUSH_EN setting. The instruction memory is a combinational pattern
// {16'hA5A5, pc[15:0]} so IF/ID contents can be traced back to their PC.
module tb_fetch_npc_stage;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  fetch_npc_stage_if bus ();

  fetch_npc_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] im(input logic [31:0] a);
    return {16'hA5A5, a[15:0]};
  endfunction

  assign bus.instr_f = im(bus.pc_f);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    $display("edge t=%0t pc_f=%h pc_d=%h pc8_d=%h instr_d=%h", $time,
             bus.pc_f, bus.pc_d, bus.pc8_d, bus.instr_d);
  endtask

  task automatic idle_inputs();
    bus.stall   = 1'b0;
    bus.flush_d = 1'b0;
    bus.cmp_eq  = 1'b0;
    bus.npc_op  = 3'd0;
    bus.imm26_d = 26'd0;
    bus.jr_addr = 32'd0;
  endtask

  // Pulse reset away from the clock edge and return just after release.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic chk4(input string name,
                      input logic [31:0] e_pcf, input logic [31:0] e_pcd,
                      input logic [31:0] e_pc8, input logic [31:0] e_ins);
    n_cmp++;
    if (bus.pc_f !== e_pcf) begin
      n_fail++;
      $display("FAIL %s pc_f got=%h exp=%h", name, bus.pc_f, e_pcf);
    end
    n_cmp++;
    if (bus.pc_d !== e_pcd) begin
      n_fail++;
      $display("FAIL %s pc_d got=%h exp=%h", name, bus.pc_d, e_pcd);
    end
    n_cmp++;
    if (bus.pc8_d !== e_pc8) begin
      n_fail++;
      $display("FAIL %s pc8_d got=%h exp=%h", name, bus.pc8_d, e_pc8);
    end
    n_cmp++;
    if (bus.instr_d !== e_ins) begin
      n_fail++;
      $display("FAIL %s instr_d got=%h exp=%h", name, bus.instr_d, e_ins);
    end
  endtask

  task automatic test_reset();
    chk4("reset_init", 32'h3000, 32'h0, 32'h0, 32'h0);
    step();
    step();
    chk4("pre_async", 32'h3008, 32'h3004, 32'h300C, im(32'h3004));
    #3;
    reset = 1'b1;
    #1;
    chk4("reset_async", 32'h3000, 32'h0, 32'h0, 32'h0);
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] pc;
    do_reset();
    pc = 32'h3000;
    n_cmp++;
    if (bus.pc_f !== pc) begin
      n_fail++;
      $display("FAIL seq_start pc_f got=%h exp=%h", bus.pc_f, pc);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk4("seq", pc + 32'd4, pc, pc + 32'd8, im(pc));
      pc = pc + 32'd4;
    end
  endtask

  task automatic test_branch();
    do_reset();
    step();
    step();
    // beq in ID at 3004, offset -1 word, taken -> 3004
    bus.npc_op  = 3'd1;
    bus.imm26_d = 26'h000FFFF;
    bus.cmp_eq  = 1'b1;
    step();
    chk4("beq_taken", 32'h3004, 32'h3008, 32'h3010, im(32'h3008));
    // bne with equal operands: not taken -> pc_f+4
    bus.npc_op = 3'd2;
    step();
    chk4("bne_not_taken", 32'h3008, 32'h3004, 32'h300C, im(32'h3004));
    // bne taken from pc_d=3004, offset +2 words -> 3010
    bus.cmp_eq  = 1'b0;
    bus.imm26_d = 26'h0000002;
    step();
    chk4("bne_taken", 32'h3010, 32'h3008, 32'h3010, im(32'h3008));
    // beq not taken from pc_d=3008
    bus.npc_op = 3'd1;
    step();
    chk4("beq_not_taken", 32'h3014, 32'h3010, 32'h3018, im(32'h3010));
    idle_inputs();
  endtask

  task automatic test_jump();
    do_reset();
    step();
    step();
    bus.npc_op  = 3'd3;
    bus.imm26_d = 26'h0000C10;
    step();
    chk4("j", 32'h3040, 32'h3008, 32'h3010, im(32'h3008));
    bus.npc_op  = 3'd4;
    bus.jr_addr = 32'h0000_3107;
    step();
    chk4("jr", 32'h3104, 32'h3040, 32'h3048, im(32'h3040));
    bus.npc_op = 3'd5;
    step();
    chk4("op5_seq", 32'h3108, 32'h3104, 32'h310C, im(32'h3104));
    bus.npc_op = 3'd7;
    step();
    chk4("op7_seq", 32'h310C, 32'h3108, 32'h3110, im(32'h3108));
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.npc_op  = 3'd4;
    bus.jr_addr = 32'hFFFF_FFFF;
    step();
    chk4("jr_top", 32'hFFFF_FFFC, 32'h3000, 32'h3008, im(32'h3000));
    bus.npc_op = 3'd0;
    step();
    chk4("pc_wrap", 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0004, im(32'hFFFF_FFFC));
    // j uses pc_d[31:28] = F
    bus.npc_op  = 3'd3;
    bus.imm26_d = 26'h0000001;
    step();
    chk4("j_region", 32'hF000_0004, 32'h0000_0000, 32'h0000_0008, im(32'h0));
    idle_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    bus.npc_op  = 3'd1;
    bus.imm26_d = 26'h000FFFF;
    bus.cmp_eq  = 1'b1;
    bus.stall   = 1'b1;
    step();
    chk4("stall1", 32'h3008, 32'h3004, 32'h300C, im(32'h3004));
    bus.cmp_eq = 1'b0;
    step();
    chk4("stall2", 32'h3008, 32'h3004, 32'h300C, im(32'h3004));
    bus.stall = 1'b0;
    step();
    chk4("stall_release", 32'h300C, 32'h3008, 32'h3010, im(32'h3008));
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    step();
    bus.flush_d = 1'b1;
    step();
`ifdef IFID_FLUSH_EN
    chk4("flush", 32'h3008, 32'h0, 32'h0, 32'h0);
`else
    chk4("flush_ignored", 32'h3008, 32'h3004, 32'h300C, im(32'h3004));
`endif
    bus.stall = 1'b1;
    step();
`ifdef IFID_FLUSH_EN
    chk4("flush_stall", 32'h3008, 32'h0, 32'h0, 32'h0);
`else
    chk4("flush_stall", 32'h3008, 32'h3004, 32'h300C, im(32'h3004));
`endif
    idle_inputs();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    idle_inputs();
    #12;
    reset = 1'b0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_back_to_back();
    test_stall();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
